// File: rtl/capture_scheduler.sv
// capture_scheduler: sequences frame captures across two cameras, one round per trigger.
// Latency: a trigger sampled in IDLE gives camX_start on the next cycle if camX_busy was low.
// Backpressure: holds in START while the camera is busy; one trigger is buffered, later ones are dropped and flagged.
// Optional feature: define CAPTURE_TIMEOUT_EN to add the WAIT_DONE watchdog that drives timeout_err.
module capture_scheduler #(
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(10000000)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  cam_enable,
  input  logic [15:0] period,
  input  logic        sw_trigger,
  input  logic        clear_flags,
  input  logic        cam0_busy,
  input  logic        cam1_busy,
  input  logic        cam0_done,
  input  logic        cam1_done,
  output logic        cam0_start,
  output logic        cam1_start,
  output logic        active_cam,
  output logic        sched_busy,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    NEXT      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic        cam0_start_q, cam0_start_d;
  logic        cam1_start_q, cam1_start_d;
  logic        sched_busy_q;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] timer_q, timer_d;

  logic        tick;
  logic        cam_any;
  logic        trig_ok;
  logic        done_act;

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;
`endif

  // Period timer: free-runs from 0 to period-1 while enabled, otherwise parked at 0.
  // The >= compare keeps the timer from running away if period shrinks below the current count.
  always_comb begin
    tick    = enable && (period != 16'd0) && (timer_q >= (period - 16'd1));
    timer_d = timer_q + 16'd1;
    if (!enable || (period == 16'd0) || tick) begin
      timer_d = 16'd0;
    end
  end

  // Trigger qualification: sw pulse and timer expiry merge into one event; ignored when nothing can run.
  always_comb begin
    cam_any  = |cam_enable;
    trig_ok  = (sw_trigger | tick) & enable & cam_any;
    done_act = active_q ? cam1_done : cam0_done;
  end

  // Next-state logic for the round sequencer, pending slot and sticky flags.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    cam0_start_d = 1'b0;
    cam1_start_d = 1'b0;
    pending_d    = pending_q;
    overrun_d    = overrun_q & ~clear_flags;
    frame_d      = frame_q;
`ifdef CAPTURE_TIMEOUT_EN
    wd_d         = '0;
    timeout_d    = timeout_q & ~clear_flags;
`endif

    case (state_q)
      IDLE: begin
        // A buffered trigger is consumed here whether or not a round can start.
        pending_d = 1'b0;
        if (enable && cam_any && (trig_ok || pending_q)) begin
          state_d  = START;
          active_d = ~cam_enable[0];
          // Pulse immediately on the START cycle when the camera is already free.
          if (cam_enable[0]) begin
            cam0_start_d = ~cam0_busy;
          end else begin
            cam1_start_d = ~cam1_busy;
          end
        end
      end

      START: begin
        if (cam0_start_q || cam1_start_q) begin
          // The start pulse is on the wire this cycle; move on.
          state_d = WAIT_DONE;
        end else if (active_q) begin
          cam1_start_d = ~cam1_busy;
        end else begin
          cam0_start_d = ~cam0_busy;
        end
      end

      WAIT_DONE: begin
        // A done from the served camera always beats a coincident watchdog expiry.
        if (done_act) begin
          state_d = NEXT;
`ifdef CAPTURE_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          state_d   = NEXT;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
`endif
        end
      end

      NEXT: begin
        // Only cam1 can follow cam0; cam_enable is re-read here.
        if (!active_q && cam_enable[1]) begin
          state_d      = START;
          active_d     = 1'b1;
          cam1_start_d = ~cam1_busy;
        end else begin
          state_d = IDLE;
          frame_d = frame_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Triggers seen mid-round: first one is buffered, any further one is lost.
    if ((state_q != IDLE) && trig_ok) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    // Disabling drops any buffered trigger; the round in flight still finishes.
    if (!enable) begin
      pending_d = 1'b0;
    end
  end

  // State and registered outputs; reset abandons any capture in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      cam0_start_q <= 1'b0;
      cam1_start_q <= 1'b0;
      sched_busy_q <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_q      <= 16'd0;
      timer_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      cam0_start_q <= cam0_start_d;
      cam1_start_q <= cam1_start_d;
      sched_busy_q <= (state_d != IDLE);
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      frame_q      <= frame_d;
      timer_q      <= timer_d;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  // Watchdog count of cycles spent waiting for done, plus its sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cam0_start  = cam0_start_q;
  assign cam1_start  = cam1_start_q;
  assign active_cam  = active_q;
  assign sched_busy  = sched_busy_q;
  assign frame_count = frame_q;
  assign overrun     = overrun_q;

endmodule
